fadd_share_arbiter: RTL
=======================

# fadd_share_arbiter

Round-robin arbiter and two-stage issue pipeline that shares one combinational `Floating_adder` between `N_REQ` requesters, such as the butterfly lanes of the radix-4 FFT. Each requester submits an operand pair and an add/sub control through a valid/ready handshake. The block registers the winning operands, drives the shared adder, registers the 32-bit IEEE-754 result, and returns it to the originating requester through a per-requester valid/ready response.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: requester index width, equal to ceil(log2(`N_REQ`)).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input `N_REQ`: requester i has an operation pending.
- `req_ready` output `N_REQ`: one-hot grant; the request is accepted in any cycle where `req_valid[i] & req_ready[i]`.
- `req_a` input `N_REQ*32`: operand a, lane i at bits [32i+31:32i].
- `req_b` input `N_REQ*32`: operand b, same packing as `req_a`.
- `req_op` input `N_REQ`: 0 selects add, 1 selects subtract (a-b).
- `rsp_valid` output `N_REQ`: one-hot; result available for requester i.
- `rsp_ready` input `N_REQ`: requester i accepts the result.
- `rsp_data` output 32: result, valid while any `rsp_valid` bit is set.
- `fa_a` output 32: shared adder operand a, driven from the S1 register.
- `fa_b` output 32: shared adder operand b, driven from the S1 register.
- `fa_ctrl` output 1: shared adder control, driven from the S1 register.
- `fa_enable` output 1: shared adder enable, equal to `s1_v`.
- `fa_ans` input 32: shared adder result (combinational).

## Operation
- Stage S1 holds `s1_v`, `s1_id`, `s1_a`, `s1_b` and `s1_op`.
- Stage S2 holds `s2_v`, `s2_id` and `s2_data`.
- `rsp_valid` = `s2_v` one-hot decoded by `s2_id`. `rsp_data` = `s2_data`.
- Retire: `ret = s2_v & rsp_ready[s2_id]`.
- S2 load enable: `adv2 = s1_v & (~s2_v | ret)`.
  - On `adv2`: S2 ← {1, `s1_id`, `fa_ans`}.
  - Else if `ret`: `s2_v` ← 0.
- S1 accept enable: `acc = |req_valid & (~s1_v | adv2)`.
  - On `acc`: S1 ← the granted lane's operands and index.
  - Else if `adv2`: `s1_v` ← 0.
- Grant (combinational): the first requester with `req_valid` set, searching from `ptr` upward modulo `N_REQ`. `req_ready` is all-zero when `acc` = 0.
- `req_ready` depends on `rsp_ready`, which is a combinational path. Requesters must not make `req_valid` depend on `req_ready`.
- Round-robin pointer: on `acc`, `ptr` ← (granted index + 1) mod `N_REQ`. Otherwise `ptr` holds.
- A granted request is never dropped and never duplicated.
- Requester i may have at most one transaction in flight beyond its own outstanding response. The bench must not issue a new request for lane i while `rsp_valid[i]` is pending and unacknowledged, or ordering is undefined.
- Arithmetic is done entirely by the shared adder; no rounding or sign fix-up happens here.
- `fa_enable` = 0 whenever S1 is empty, so the adder outputs 0 and no stale value is captured.

## Timing
- Reset values: `s1_v`, `s2_v`, `ptr`, all data and id registers, `rsp_valid`, `rsp_data`, `fa_*` = 0. `req_ready` = 0 while `rst_n` = 0.
- Latency: a request accepted at edge T has `rsp_valid` high in the cycle after edge T+1, i.e. 2 cycles.
- Throughput is 1 operation per cycle when `rsp_ready` is held high.
- Backpressure:
  - With S2 stalled, S1 still fills once, then `req_ready` = 0.
  - With both stages full, everything freezes.
  - `rsp_data` and `rsp_valid` stay stable until retired.
- Simultaneous retire, advance and accept in the same cycle are all legal and all take effect.
- Reset asserted mid-operation clears both stages immediately and asynchronously. In-flight results are discarded and `ptr` returns to 0.

## Test plan
- Single request, lane 0: a = 0x3F800000, b = 0x40000000, op = 0. Required: `rsp_valid` = 0001 and `rsp_data` = 0x40400000 exactly 2 cycles after acceptance.
- Lane 2 subtract: 0x40400000 − 0x3F800000. Required: `rsp_data` = 0x40000000 with `rsp_valid` = 0100. Equal operands with op = 1 return 0x00000000.
- All four `req_valid` held high, `rsp_ready` = 1111. Required: grants 0, 1, 2, 3, 0, 1 on consecutive cycles and one response per cycle, in the same order.
- Lane 1 response with `rsp_ready[1]` = 0 for 3 cycles while other lanes request. Required: S1 fills, then `req_ready` = 0; `rsp_data` is held constant; after release, the pending S1 result appears next cycle.
- `rst_n` pulsed low while both stages are full. Required: all outputs go to 0 asynchronously; after release, the first grant goes to lane 0.
- Lanes 1 and 3 only, continuous. Required: grants alternate 1, 3, 1, 3, and lane 0 and lane 2 are never granted.

Source files
------------

// File: rtl/fadd_share_arbiter.sv
// Round-robin share of one combinational float adder across N_REQ requesters.
// Two-stage issue (S1 operands, S2 result), 2-cycle latency, stalls on response backpressure.
module fadd_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    input  logic [N_REQ-1:0]     req_op,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [31:0]          fa_a,
    output logic [31:0]          fa_b,
    output logic                 fa_ctrl,
    output logic                 fa_enable,
    input  logic [31:0]          fa_ans
);

    logic             r_s1_v;
    logic [ID_W-1:0]  r_s1_id;
    logic [31:0]      r_s1_a;
    logic [31:0]      r_s1_b;
    logic             r_s1_op;
    logic             r_s2_v;
    logic [ID_W-1:0]  r_s2_id;
    logic [31:0]      r_s2_data;
    logic [ID_W-1:0]  r_ptr;

    logic             w_ret;
    logic             w_adv2;
    logic             w_acc;
    logic             w_found;
    logic [ID_W-1:0]  w_gnt_id;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [31:0]      w_a_arr [N_REQ];
    logic [31:0]      w_b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign w_a_arr[g] = req_a[32*g +: 32];
        assign w_b_arr[g] = req_b[32*g +: 32];
    end

    assign w_ret  = r_s2_v & rsp_ready[r_s2_id];
    assign w_adv2 = r_s1_v & (~r_s2_v | w_ret);
    // rst_n gates acceptance so no grant is advertised while held in reset.
    assign w_acc  = rst_n & w_found & (~r_s1_v | w_adv2);

    always_comb begin
        logic [ID_W-1:0] w_idx;
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
    end

    assign w_ptr_nxt = ID_W'((int'(w_gnt_id) + 1) % N_REQ);

    always_comb begin
        req_ready           = '0;
        req_ready[w_gnt_id] = w_acc;
    end

    always_comb begin
        rsp_valid          = '0;
        rsp_valid[r_s2_id] = r_s2_v;
    end

    assign rsp_data  = r_s2_data;
    assign fa_a      = r_s1_a;
    assign fa_b      = r_s1_b;
    assign fa_ctrl   = r_s1_op;
    assign fa_enable = r_s1_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v    <= 1'b0;
            r_s2_id   <= '0;
            r_s2_data <= '0;
        end else if (w_adv2) begin
            r_s2_v    <= 1'b1;
            r_s2_id   <= r_s1_id;
            r_s2_data <= fa_ans;
        end else if (w_ret) begin
            r_s2_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v  <= 1'b0;
            r_s1_id <= '0;
            r_s1_a  <= '0;
            r_s1_b  <= '0;
            r_s1_op <= 1'b0;
        end else if (w_acc) begin
            r_s1_v  <= 1'b1;
            r_s1_id <= w_gnt_id;
            r_s1_a  <= w_a_arr[w_gnt_id];
            r_s1_b  <= w_b_arr[w_gnt_id];
            r_s1_op <= req_op[w_gnt_id];
        end else if (w_adv2) begin
            r_s1_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_acc) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
